// File: rtl/hazard_pkg.sv
// hazard_pkg: shared types and limits for the pipeline hazard controller.
//   hazState_t       - controller FSM state (RUN=0, LU_STALL=1)
//   LU_STALL_CYC_MAX - largest supported load-use stall length
package hazard_pkg;

  localparam int unsigned LU_STALL_CYC_MAX = 15;

  typedef enum logic [0:0] {
    RUN      = 1'b0,
    LU_STALL = 1'b1
  } hazState_t;

endpackage

// File: rtl/hazard_detect.sv
// hazard_detect: combinational load-use hazard comparator.
// A hit needs a load in ID/EX writing a non-$zero register that the
// instruction in ID actually reads through rs or rt.
// Ports:
//   MemRd_ID_EX       in  ID/EX instruction is a load
//   RegisterRt_ID_EX  in  load destination register
//   RegisterRs_IF_ID  in  ID-stage rs
//   RegisterRt_IF_ID  in  ID-stage rt
//   UseRs_IF_ID       in  ID instruction reads rs
//   UseRt_IF_ID       in  ID instruction reads rt
//   luHit_c           out load-use hazard present (combinational)
module hazard_detect #(
  parameter int unsigned REG_AW = 5
) (
  input  logic              MemRd_ID_EX,
  input  logic [REG_AW-1:0] RegisterRt_ID_EX,
  input  logic [REG_AW-1:0] RegisterRs_IF_ID,
  input  logic [REG_AW-1:0] RegisterRt_IF_ID,
  input  logic              UseRs_IF_ID,
  input  logic              UseRt_IF_ID,
  output logic              luHit_c
);

  logic rsMatch;
  logic rtMatch;
  logic dstNonZero;

  // $zero is never a real dependency, so a load to r0 cannot cause a hit
  always_comb begin
    rsMatch    = UseRs_IF_ID && (RegisterRs_IF_ID == RegisterRt_ID_EX);
    rtMatch    = UseRt_IF_ID && (RegisterRt_IF_ID == RegisterRt_ID_EX);
    dstNonZero = (RegisterRt_ID_EX != '0);
    luHit_c    = MemRd_ID_EX && dstNonZero && (rsMatch || rtMatch);
  end

endmodule

// File: rtl/hazard_ctrl.sv
// hazard_ctrl: pipeline hazard controller for the 5-stage pipeline.
// Handles multi-cycle load-use stalls, MEM-stage wait freeze and
// taken-branch squash; drives pipeline register write-enables/flushes.
// Optional build macro: HAZARD_STALL_CNT_EN adds StallCycles/SquashCount.
// Ports:
//   clk, rst_n                       clock, synchronous active-low reset
//   MemRd_ID_EX, RegisterRt_ID_EX    load in ID/EX and its destination
//   RegisterRs_IF_ID, RegisterRt_IF_ID, UseRs_IF_ID, UseRt_IF_ID
//                                    ID-stage source operands and use flags
//   BranchTaken_EX_MEM               taken branch/jump resolved in EX/MEM
//   MemBusy                          MEM-stage access still pending
//   PCWr, IF_ID_Wr, ID_EX_Wr, EX_MEM_Wr      write-enables (combinational)
//   IF_ID_Flush, ID_EX_Flush, MEM_WB_Flush   bubble inserts (combinational)
//   StallCycles, SquashCount         event counters (HAZARD_STALL_CNT_EN)
module hazard_ctrl
  import hazard_pkg::*;
#(
  parameter int unsigned REG_AW       = 5,
  parameter int unsigned LU_STALL_CYC = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              MemRd_ID_EX,
  input  logic [REG_AW-1:0] RegisterRt_ID_EX,
  input  logic [REG_AW-1:0] RegisterRs_IF_ID,
  input  logic [REG_AW-1:0] RegisterRt_IF_ID,
  input  logic              UseRs_IF_ID,
  input  logic              UseRt_IF_ID,
  input  logic              BranchTaken_EX_MEM,
  input  logic              MemBusy,
  output logic              PCWr,
  output logic              IF_ID_Wr,
  output logic              ID_EX_Wr,
  output logic              EX_MEM_Wr,
  output logic              IF_ID_Flush,
  output logic              ID_EX_Flush,
  output logic              MEM_WB_Flush
`ifdef HAZARD_STALL_CNT_EN
  ,
  output logic [31:0]       StallCycles,
  output logic [31:0]       SquashCount
`endif
);

  // Out-of-range stall lengths are clamped into 1..LU_STALL_CYC_MAX
  localparam int unsigned STALL_CYC =
    (LU_STALL_CYC < 1) ? 1 :
    ((LU_STALL_CYC > LU_STALL_CYC_MAX) ? LU_STALL_CYC_MAX : LU_STALL_CYC);
  localparam int unsigned CNT_W = $clog2(STALL_CYC + 1);

  hazState_t        state;
  hazState_t        stateNext;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cntNext;

  logic luHit_c;
  logic freeze_c;
  logic squash_c;
  logic stall_c;

  hazard_detect #(
    .REG_AW (REG_AW)
  ) uDetect (
    .MemRd_ID_EX      (MemRd_ID_EX),
    .RegisterRt_ID_EX (RegisterRt_ID_EX),
    .RegisterRs_IF_ID (RegisterRs_IF_ID),
    .RegisterRt_IF_ID (RegisterRt_IF_ID),
    .UseRs_IF_ID      (UseRs_IF_ID),
    .UseRt_IF_ID      (UseRt_IF_ID),
    .luHit_c          (luHit_c)
  );

  // Priority qualification: reset > freeze > squash > stall
  always_comb begin
    freeze_c = rst_n && MemBusy;
    squash_c = rst_n && !MemBusy && BranchTaken_EX_MEM;
    stall_c  = rst_n && !MemBusy && !BranchTaken_EX_MEM &&
               ((state == LU_STALL) || luHit_c);
  end

  // State register
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= RUN;
      cnt   <= '0;
    end else begin
      state <= stateNext;
      cnt   <= cntNext;
    end
  end

  // Next state and output priority mux
  always_comb begin
    stateNext    = state;
    cntNext      = cnt;
    PCWr         = 1'b1;
    IF_ID_Wr     = 1'b1;
    ID_EX_Wr     = 1'b1;
    EX_MEM_Wr    = 1'b1;
    IF_ID_Flush  = 1'b0;
    ID_EX_Flush  = 1'b0;
    MEM_WB_Flush = 1'b0;

    if (!rst_n) begin
      PCWr         = 1'b0;
      IF_ID_Wr     = 1'b0;
      IF_ID_Flush  = 1'b1;
      ID_EX_Flush  = 1'b1;
      MEM_WB_Flush = 1'b1;
    end else if (freeze_c) begin
      // Freeze: nothing advances, state and count hold
      PCWr         = 1'b0;
      IF_ID_Wr     = 1'b0;
      ID_EX_Wr     = 1'b0;
      EX_MEM_Wr    = 1'b0;
      MEM_WB_Flush = 1'b1;
    end else if (squash_c) begin
      // The offending load is squashed, so any stall in progress is dropped
      IF_ID_Flush = 1'b1;
      ID_EX_Flush = 1'b1;
      stateNext   = RUN;
      cntNext     = '0;
    end else if (stall_c) begin
      PCWr        = 1'b0;
      IF_ID_Wr    = 1'b0;
      ID_EX_Flush = 1'b1;
      if (state == RUN) begin
        // First bubble is this cycle; the rest are counted in LU_STALL
        if (STALL_CYC > 1) begin
          stateNext = LU_STALL;
          cntNext   = CNT_W'(STALL_CYC - 1);
        end
      end else begin
        cntNext = cnt - CNT_W'(1);
        if (cnt <= CNT_W'(1)) begin
          stateNext = RUN;
        end
      end
    end
  end

`ifdef HAZARD_STALL_CNT_EN
  // Event counters, wrap naturally at 2^32
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      StallCycles <= '0;
      SquashCount <= '0;
    end else begin
      if (stall_c) begin
        StallCycles <= StallCycles + 32'd1;
      end
      if (squash_c) begin
        SquashCount <= SquashCount + 32'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// tb_hazard_ctrl: self-checking bench for hazard_ctrl. Two instances
// (stall lengths 1 and 3) share stimulus; each is compared every cycle
// against a remaining-bubble reference model.
module tb_hazard_ctrl;

  localparam int unsigned REG_AW = 5;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              memRd;
  logic [REG_AW-1:0] rtEx;
  logic [REG_AW-1:0] rsId;
  logic [REG_AW-1:0] rtId;
  logic              useRs;
  logic              useRt;
  logic              brTaken;
  logic              memBusy;

  logic [6:0] outs [2];
`ifdef HAZARD_STALL_CNT_EN
  logic [31:0] stallCycles [2];
  logic [31:0] squashCount [2];
`endif

  int checks   = 0;
  int failures = 0;

  int stallLen [2] = '{1, 3};
  int remain   [2];
  int expStall [2];
  int expSquash[2];

  always #5 clk = ~clk;

  hazard_ctrl #(.REG_AW(REG_AW), .LU_STALL_CYC(1)) uDut1 (
    .clk(clk), .rst_n(rst_n), .MemRd_ID_EX(memRd), .RegisterRt_ID_EX(rtEx),
    .RegisterRs_IF_ID(rsId), .RegisterRt_IF_ID(rtId),
    .UseRs_IF_ID(useRs), .UseRt_IF_ID(useRt),
    .BranchTaken_EX_MEM(brTaken), .MemBusy(memBusy),
    .PCWr(outs[0][6]), .IF_ID_Wr(outs[0][5]), .ID_EX_Wr(outs[0][4]),
    .EX_MEM_Wr(outs[0][3]), .IF_ID_Flush(outs[0][2]),
    .ID_EX_Flush(outs[0][1]), .MEM_WB_Flush(outs[0][0])
`ifdef HAZARD_STALL_CNT_EN
    , .StallCycles(stallCycles[0]), .SquashCount(squashCount[0])
`endif
  );

  hazard_ctrl #(.REG_AW(REG_AW), .LU_STALL_CYC(3)) uDut3 (
    .clk(clk), .rst_n(rst_n), .MemRd_ID_EX(memRd), .RegisterRt_ID_EX(rtEx),
    .RegisterRs_IF_ID(rsId), .RegisterRt_IF_ID(rtId),
    .UseRs_IF_ID(useRs), .UseRt_IF_ID(useRt),
    .BranchTaken_EX_MEM(brTaken), .MemBusy(memBusy),
    .PCWr(outs[1][6]), .IF_ID_Wr(outs[1][5]), .ID_EX_Wr(outs[1][4]),
    .EX_MEM_Wr(outs[1][3]), .IF_ID_Flush(outs[1][2]),
    .ID_EX_Flush(outs[1][1]), .MEM_WB_Flush(outs[1][0])
`ifdef HAZARD_STALL_CNT_EN
    , .StallCycles(stallCycles[1]), .SquashCount(squashCount[1])
`endif
  );

  task automatic checkVal(input string tag, input logic [31:0] got,
                          input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h @%0t", tag, got, exp, $time);
    end
  endtask

  // Reference hazard rule taken straight from the operand-match definition
  function automatic bit refHit();
    bit rsDep = useRs && (rsId == rtEx);
    bit rtDep = useRt && (rtId == rtEx);
    return memRd && (rtEx != 0) && (rsDep || rtDep);
  endfunction

  // Expected {PCWr,IF_ID_Wr,ID_EX_Wr,EX_MEM_Wr,IF_ID_Fl,ID_EX_Fl,MEM_WB_Fl}
  function automatic logic [6:0] refOut(input bit hit, input int rem);
    if (!rst_n)               return 7'b0011_111;
    if (memBusy)              return 7'b0000_001;
    if (brTaken)              return 7'b1111_110;
    if (rem > 0 || hit)       return 7'b0011_010;
    return 7'b1111_000;
  endfunction

  task automatic runCycle(input bit r, input bit m, input int re,
                          input int rs, input int rt, input bit ur,
                          input bit ut, input bit b, input bit mb);
    bit hit;
    rst_n   = r;
    memRd   = m;
    rtEx    = REG_AW'(re);
    rsId    = REG_AW'(rs);
    rtId    = REG_AW'(rt);
    useRs   = ur;
    useRt   = ut;
    brTaken = b;
    memBusy = mb;
    @(negedge clk);
    hit = refHit();
    for (int k = 0; k < 2; k++) begin
      checkVal($sformatf("outs_len%0d", stallLen[k]), 32'(outs[k]),
               32'(refOut(hit, remain[k])));
`ifdef HAZARD_STALL_CNT_EN
      checkVal($sformatf("stallCycles_len%0d", stallLen[k]), stallCycles[k],
               32'(expStall[k]));
      checkVal($sformatf("squashCount_len%0d", stallLen[k]), squashCount[k],
               32'(expSquash[k]));
`endif
      // Advance the model to the next edge
      if (!rst_n) begin
        remain[k]    = 0;
        expStall[k]  = 0;
        expSquash[k] = 0;
      end else if (memBusy) begin
        remain[k] = remain[k];
      end else if (brTaken) begin
        remain[k] = 0;
        expSquash[k]++;
      end else if (remain[k] > 0 || hit) begin
        expStall[k]++;
        if (remain[k] > 0) remain[k]--;
        else               remain[k] = stallLen[k] - 1;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) runCycle(1, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  initial begin
    for (int k = 0; k < 2; k++) begin
      remain[k] = 0; expStall[k] = 0; expSquash[k] = 0;
    end
    rst_n = 0; memRd = 0; rtEx = '0; rsId = '0; rtId = '0;
    useRs = 0; useRt = 0; brTaken = 0; memBusy = 0;
    @(posedge clk);
    #1;

    // Reset and first run-state cycle
    runCycle(0, 0, 0, 0, 0, 0, 0, 0, 0);
    idle(1);

    // Load to r8, ID reads r8 via rs
    runCycle(1, 1, 8, 8, 3, 1, 1, 0, 0);
    idle(4);

    // Load to r0 read as r0, and rt match with rt unused: no stall
    runCycle(1, 1, 0, 0, 0, 1, 1, 0, 0);
    runCycle(1, 1, 9, 2, 9, 1, 0, 0, 0);
    idle(1);

    // Memory wait for two cycles in the middle of a stall
    runCycle(1, 1, 8, 8, 0, 1, 0, 0, 0);
    runCycle(1, 0, 0, 0, 0, 0, 0, 0, 1);
    runCycle(1, 0, 0, 0, 0, 0, 0, 0, 1);
    idle(4);

    // Hazard and taken branch together
    runCycle(1, 1, 5, 0, 5, 0, 1, 1, 0);
    idle(2);

    // Squash mid-stall
    runCycle(1, 1, 7, 7, 0, 1, 0, 0, 0);
    runCycle(1, 0, 0, 0, 0, 0, 0, 1, 0);
    idle(2);

    // Reset mid-stall
    runCycle(1, 1, 4, 4, 0, 1, 0, 0, 0);
    runCycle(0, 0, 0, 0, 0, 0, 0, 0, 0);
    idle(3);

    // Randomized traffic with small register range to provoke hits
    for (int i = 0; i < 3000; i++) begin
      runCycle(($urandom_range(99) >= 2),
               ($urandom_range(99) < 55),
               int'($urandom_range(3)),
               int'($urandom_range(3)),
               int'($urandom_range(3)),
               ($urandom_range(99) < 70),
               ($urandom_range(99) < 50),
               ($urandom_range(99) < 8),
               ($urandom_range(99) < 15));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
